ctrl_pipe: RTL
==============

Name: ctrl_pipe

Overview:
- Parametrised successor to the RV32I main control decoder.
- Decodes opcode in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and generates an ID stall with a configurable bubble count.
- Applies EX redirect flushes and flags illegal opcodes.
- Sits between the IF/ID register and the datapath stage registers; the datapath consumes the per-stage control outputs.

Parameters:
REG_W, 5, register-index width
ULA_OP_W, 2, width of ALU operation class
NUM_STALL, 1, bubbles per load-use hazard (1 = MEM->EX forwarding present, 2 = none); legal 1..2
HAZARD_EN, 1, 0 disables load-use detection (stall_out tied 0)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
id_valid  in  1  IF/ID holds a real instruction
opcode  in  7  instruction[6:0] in ID
id_rd  in  REG_W  destination index in ID
id_rs1  in  REG_W  source 1 index in ID
id_rs2  in  REG_W  source 2 index in ID
flush  in  1  EX redirect (taken branch/jump); kill ID and EX contents
stall_out  out  1  hold PC and IF/ID this cycle
illegal_out  out  1  registered: unknown opcode entered EX
ex_valid  out  1  EX holds a real instruction
ex_ula_op  out  ULA_OP_W  00 add, 01 branch compare, 10 funct-decoded
ex_alu_src1  out  2  00 rs1, 01 pc, 10 zero
ex_alu_src2  out  2  00 rs2, 01 imm, 10 constant 4
ex_branch, ex_jump, ex_jalr  out  1 each  EX control-flow flags
ex_rd  out  REG_W  EX destination index
mem_rd, mem_wr, mem_reg_wr, mem_mux_reg_wr  out  1 each  MEM-stage controls
mem_rd_idx  out  REG_W  MEM destination index
wb_reg_wr, wb_mux_reg_wr  out  1 each  WB-stage controls (mux 1 = memory data)
wb_rd_idx  out  REG_W  WB destination index

Behaviour:
- Reset: all stage registers, valids, illegal_out and the stall counter clear to 0 immediately; all outputs read 0 during reset.
- Decode is combinational in ID. Fields are (ula_op, src1, src2, mem_rd, mem_wr, reg_wr, mux, branch, jump, jalr) and uses_rs1/uses_rs2:
  - R 0110011: 10,00,00,0,0,1,0,0,0,0; uses rs1 and rs2.
  - I 0010011: 10,00,01,0,0,1,0; uses rs1.
  - Load 0000011: 00,00,01,1,0,1,1; uses rs1.
  - S 0100011: 00,00,01,0,1,0,0; uses rs1 and rs2.
  - B 1100011: 01,00,00,0,0,0,0, branch=1; uses rs1 and rs2.
  - LUI 0110111: 00,10,01, reg_wr=1; uses neither.
  - AUIPC 0010111: 00,01,01, reg_wr=1; uses neither.
  - JAL 1101111: 00,01,10, reg_wr=1, jump=1; uses neither.
  - JALR 1100111: 00,01,10, reg_wr=1, jump=1, jalr=1; uses rs1.
  - Any other opcode: all fields 0, illegal=1.
- reg_wr is forced to 0 when id_rd==0.
- Pipeline advance: every cycle EX<-ID, MEM<-EX, WB<-MEM. Latency from opcode to ex_* is 1 cycle, to mem_* 2 cycles, to wb_* 3 cycles.
- Bubble: EX is loaded with all-zero control and ex_valid=0. A bubble is inserted when any of the following holds:
  - id_valid=0;
  - stall_out=1;
  - flush=1.
- Load-use hazard (HAZARD_EN=1): hazard = ex_valid & ex mem_rd & ex_rd!=0 & ((uses_rs1 & id_rs1==ex_rd) | (uses_rs2 & id_rs2==ex_rd)). Stall FSM:
  - IDLE: hazard -> stall_out=1, counter loads NUM_STALL-1; go to HOLD if the counter value is nonzero, else stay IDLE.
  - HOLD: stall_out=1, counter decrements; return to IDLE when it reaches 0.
- Flush priority: flush overrides stall. It clears EX, forces the FSM to IDLE and deasserts stall_out that cycle. MEM and WB advance unaffected.
- illegal_out: registered, equals ID illegal & id_valid & ~stall & ~flush. It is a 1-cycle pulse aligned with ex_valid timing.
- Simultaneous hazard and id_valid=0: no stall; the hazard term is gated by id_valid.
- rst asserted mid-stall: the FSM returns to IDLE and all in-flight control is discarded.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode constants;
  - ULA_OP and ALU_SRC encodings;
  - the control-bundle packed struct;
  - the MUX_WB_MEM constant.
- One combinational sub-module, ctrl_decode, maps opcode to bundle, uses_rs1, uses_rs2 and illegal.
- ctrl_pipe instantiates ctrl_decode and owns the stage registers and the hazard FSM.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with traffic in flight -> all outputs read 0 immediately; after release, ex_valid=0.
- Straight-line program: add x3 (0110011) then lw x5 (0000011) -> ex_ula_op=10 at t+1, ex_alu_src2=01 at t+2, mem_rd=1 at t+3, wb_mux_reg_wr=1 at t+4.
- Load-use, NUM_STALL=1: lw x5 followed by add x6,x5,x1 -> stall_out=1 for exactly 1 cycle, one bubble in EX, add reaches EX one cycle late.
- Load-use, NUM_STALL=2: same sequence -> stall_out=1 for 2 cycles, 2 bubbles. With lw x0 instead -> no stall.
- Flush during stall: assert flush in the first stall cycle (NUM_STALL=2) -> stall_out=0 that cycle, ex_valid=0 next cycle, FSM idle.
- Misc decode: opcode 1111111 -> illegal_out pulses 1 cycle, no write enables. beq (1100011) -> ex_branch=1, ex_ula_op=01, mem_reg_wr=0.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the pipelined RV32I control path: opcodes, operand
// select encodings and the control bundle carried from ID through EX.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ULA_ADD    = 2'b00,
        ULA_BRANCH = 2'b01,
        ULA_FUNCT  = 2'b10
    } ula_op_e;

    typedef enum logic [1:0] {
        SRC1_RS1  = 2'b00,
        SRC1_PC   = 2'b01,
        SRC1_ZERO = 2'b10
    } alu_src1_e;

    typedef enum logic [1:0] {
        SRC2_RS2  = 2'b00,
        SRC2_IMM  = 2'b01,
        SRC2_FOUR = 2'b10
    } alu_src2_e;

    // Write-back mux select: 1 picks memory data, 0 picks the ALU result.
    localparam logic MUX_WB_MEM = 1'b1;
    localparam logic MUX_WB_ALU = 1'b0;

    typedef struct packed {
        ula_op_e   ula_op;
        alu_src1_e src1;
        alu_src2_e src2;
        logic      mem_rd;
        logic      mem_wr;
        logic      reg_wr;
        logic      mux;
        logic      branch;
        logic      jump;
        logic      jalr;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        ula_op : ULA_ADD,
        src1   : SRC1_RS1,
        src2   : SRC2_RS2,
        mem_rd : 1'b0,
        mem_wr : 1'b0,
        reg_wr : 1'b0,
        mux    : MUX_WB_ALU,
        branch : 1'b0,
        jump   : 1'b0,
        jalr   : 1'b0
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } stall_st_e;

endpackage

// File: rtl/ctrl_pipe_if.sv
// ID-side inputs and per-stage control outputs of the control pipeline.
// The front end / datapath side uses master, the control pipeline uses slave.
interface ctrl_pipe_if #(
    parameter int REG_W    = 5,
    parameter int ULA_OP_W = 2
) ();

    logic                id_valid;
    logic [6:0]          opcode;
    logic [REG_W-1:0]    id_rd;
    logic [REG_W-1:0]    id_rs1;
    logic [REG_W-1:0]    id_rs2;
    logic                flush;

    logic                stall_out;
    logic                illegal_out;
    logic                ex_valid;
    logic [ULA_OP_W-1:0] ex_ula_op;
    logic [1:0]          ex_alu_src1;
    logic [1:0]          ex_alu_src2;
    logic                ex_branch;
    logic                ex_jump;
    logic                ex_jalr;
    logic [REG_W-1:0]    ex_rd;
    logic                mem_rd;
    logic                mem_wr;
    logic                mem_reg_wr;
    logic                mem_mux_reg_wr;
    logic [REG_W-1:0]    mem_rd_idx;
    logic                wb_reg_wr;
    logic                wb_mux_reg_wr;
    logic [REG_W-1:0]    wb_rd_idx;

    modport master (
        output id_valid, opcode, id_rd, id_rs1, id_rs2, flush,
        input  stall_out, illegal_out, ex_valid, ex_ula_op, ex_alu_src1,
               ex_alu_src2, ex_branch, ex_jump, ex_jalr, ex_rd,
               mem_rd, mem_wr, mem_reg_wr, mem_mux_reg_wr, mem_rd_idx,
               wb_reg_wr, wb_mux_reg_wr, wb_rd_idx
    );

    modport slave (
        input  id_valid, opcode, id_rd, id_rs1, id_rs2, flush,
        output stall_out, illegal_out, ex_valid, ex_ula_op, ex_alu_src1,
               ex_alu_src2, ex_branch, ex_jump, ex_jalr, ex_rd,
               mem_rd, mem_wr, mem_reg_wr, mem_mux_reg_wr, mem_rd_idx,
               wb_reg_wr, wb_mux_reg_wr, wb_rd_idx
    );

endinterface

// File: rtl/ctrl_pipe_decode.sv
// Combinational RV32I main decoder: opcode to control bundle, source-register
// usage (for hazard detection) and an illegal-opcode flag.
module ctrl_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output ctrl_t      ctrl,
    output logic       uses_rs1,
    output logic       uses_rs2,
    output logic       illegal
);

    always_comb begin
        ctrl     = CTRL_NOP;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.ula_op = ULA_FUNCT;
                ctrl.reg_wr = 1'b1;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            OP_I: begin
                ctrl.ula_op = ULA_FUNCT;
                ctrl.src2   = SRC2_IMM;
                ctrl.reg_wr = 1'b1;
                uses_rs1    = 1'b1;
            end
            OP_LOAD: begin
                ctrl.src2   = SRC2_IMM;
                ctrl.mem_rd = 1'b1;
                ctrl.reg_wr = 1'b1;
                ctrl.mux    = MUX_WB_MEM;
                uses_rs1    = 1'b1;
            end
            OP_STORE: begin
                ctrl.src2   = SRC2_IMM;
                ctrl.mem_wr = 1'b1;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.ula_op = ULA_BRANCH;
                ctrl.branch = 1'b1;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            OP_LUI: begin
                ctrl.src1   = SRC1_ZERO;
                ctrl.src2   = SRC2_IMM;
                ctrl.reg_wr = 1'b1;
            end
            OP_AUIPC: begin
                ctrl.src1   = SRC1_PC;
                ctrl.src2   = SRC2_IMM;
                ctrl.reg_wr = 1'b1;
            end
            OP_JAL: begin
                ctrl.src1   = SRC1_PC;
                ctrl.src2   = SRC2_FOUR;
                ctrl.reg_wr = 1'b1;
                ctrl.jump   = 1'b1;
            end
            OP_JALR: begin
                ctrl.src1   = SRC1_PC;
                ctrl.src2   = SRC2_FOUR;
                ctrl.reg_wr = 1'b1;
                ctrl.jump   = 1'b1;
                ctrl.jalr   = 1'b1;
                uses_rs1    = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined RV32I control path: decodes in ID, carries control through
// ID/EX, EX/MEM and MEM/WB, and generates load-use stalls and flush bubbles.
module ctrl_pipe
    import rv_ctrl_pkg::*;
#(
    parameter int REG_W     = 5,
    parameter int ULA_OP_W  = 2,
    parameter int NUM_STALL = 1,
    parameter int HAZARD_EN = 1
) (
    input logic       clk,
    input logic       rst,
    ctrl_pipe_if.slave bus
);

    localparam logic [1:0] STALL_LOAD = 2'(NUM_STALL - 1);

    ctrl_t            dec_ctrl;
    ctrl_t            ctrl_id;
    logic             uses_rs1;
    logic             uses_rs2;
    logic             id_illegal;

    ctrl_t            ctrl_p0;
    logic             vld_p0;
    logic [REG_W-1:0] rd_p0;
    logic             ill_p0;

    logic             mem_rd_p1;
    logic             mem_wr_p1;
    logic             reg_wr_p1;
    logic             mux_p1;
    logic [REG_W-1:0] rd_p1;

    logic             reg_wr_p2;
    logic             mux_p2;
    logic [REG_W-1:0] rd_p2;

    stall_st_e        state;
    stall_st_e        state_nxt;
    logic [1:0]       cnt;
    logic [1:0]       cnt_nxt;
    logic             hazard;
    logic             stall;
    logic             bubble;

    ctrl_decode u_decode (
        .opcode   (bus.opcode),
        .ctrl     (dec_ctrl),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2),
        .illegal  (id_illegal)
    );

    // Writes to x0 are architecturally discarded, so never request them.
    always_comb begin
        ctrl_id = dec_ctrl;
        if (bus.id_rd == '0) begin
            ctrl_id.reg_wr = 1'b0;
        end
    end

    generate
        if (HAZARD_EN != 0) begin : g_hazard
            assign hazard = bus.id_valid & vld_p0 & ctrl_p0.mem_rd & (rd_p0 != '0) &
                            ((uses_rs1 & (bus.id_rs1 == rd_p0)) |
                             (uses_rs2 & (bus.id_rs2 == rd_p0)));
        end else begin : g_no_hazard
            assign hazard = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A redirect kills whatever the stall was protecting, so it wins outright.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        if (bus.flush) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hazard) begin
                        stall   = 1'b1;
                        cnt_nxt = STALL_LOAD;
                        if (STALL_LOAD != 2'd0) begin
                            state_nxt = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    stall   = 1'b1;
                    cnt_nxt = cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign bubble = ~bus.id_valid | stall | bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_p0   <= CTRL_NOP;
            vld_p0    <= 1'b0;
            rd_p0     <= '0;
            ill_p0    <= 1'b0;
            mem_rd_p1 <= 1'b0;
            mem_wr_p1 <= 1'b0;
            reg_wr_p1 <= 1'b0;
            mux_p1    <= 1'b0;
            rd_p1     <= '0;
            reg_wr_p2 <= 1'b0;
            mux_p2    <= 1'b0;
            rd_p2     <= '0;
        end else begin
            // ID -> EX
            if (bubble) begin
                ctrl_p0 <= CTRL_NOP;
                vld_p0  <= 1'b0;
                rd_p0   <= '0;
            end else begin
                ctrl_p0 <= ctrl_id;
                vld_p0  <= 1'b1;
                rd_p0   <= bus.id_rd;
            end
            ill_p0    <= id_illegal & ~bubble;
            // EX -> MEM
            mem_rd_p1 <= ctrl_p0.mem_rd;
            mem_wr_p1 <= ctrl_p0.mem_wr;
            reg_wr_p1 <= ctrl_p0.reg_wr;
            mux_p1    <= ctrl_p0.mux;
            rd_p1     <= rd_p0;
            // MEM -> WB
            reg_wr_p2 <= reg_wr_p1;
            mux_p2    <= mux_p1;
            rd_p2     <= rd_p1;
        end
    end

    assign bus.stall_out      = stall;
    assign bus.illegal_out    = ill_p0;
    assign bus.ex_valid       = vld_p0;
    assign bus.ex_ula_op      = ULA_OP_W'(ctrl_p0.ula_op);
    assign bus.ex_alu_src1    = ctrl_p0.src1;
    assign bus.ex_alu_src2    = ctrl_p0.src2;
    assign bus.ex_branch      = ctrl_p0.branch;
    assign bus.ex_jump        = ctrl_p0.jump;
    assign bus.ex_jalr        = ctrl_p0.jalr;
    assign bus.ex_rd          = rd_p0;
    assign bus.mem_rd         = mem_rd_p1;
    assign bus.mem_wr         = mem_wr_p1;
    assign bus.mem_reg_wr     = reg_wr_p1;
    assign bus.mem_mux_reg_wr = mux_p1;
    assign bus.mem_rd_idx     = rd_p1;
    assign bus.wb_reg_wr      = reg_wr_p2;
    assign bus.wb_mux_reg_wr  = mux_p2;
    assign bus.wb_rd_idx      = rd_p2;

endmodule
